servo_int_ctrl: RTL
===================

# servo_int_ctrl

Interrupt controller for the servo-disable switches. Synchronises and optionally debounces NUM_SRC active-low push-button inputs, latches each press as a pending event, and presents one event at a time to the processor fabric interrupt as a level held until acknowledged. It also owns the servo enable: any press kills the servos, and only a software re-enable restores them. Sits between the board switches and the MSS FABINT input, driving the servo PWM enable.

## Interface
- NUM_SRC, 2, number of switch sources (1..8)
- DEBOUNCE_CYCLES, 1000, stable-level cycles required before a debounced transition is accepted (only with DEBOUNCE_EN)
- HOLDOFF_CYCLES, 16, idle gap enforced between acknowledge and the next interrupt assertion (>=1)

- clock  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- sw  in  NUM_SRC  raw switch inputs, active-low (0 = pressed)
- ack  in  1  one-cycle pulse from CPU acknowledging the current interrupt
- servo_en_set  in  1  one-cycle pulse from CPU requesting servo re-enable
- int_out  out  1  fabric interrupt level; high while an event awaits ack
- cause  out  NUM_SRC  one-hot source of the event currently presented; 0 when none
- pending  out  NUM_SRC  latched, not-yet-acknowledged press events
- servo_en  out  1  servo drive enable

## Operation
- Reset values: int_out=0, cause=0, pending=0, servo_en=0, all sync/debounce flops 0 (released), counters 0, FSM=IDLE.
- Input path per source: invert sw, two-flop synchroniser, then previous-value flop; press event = synchronised 1 and previous 0 (rising edge of "pressed"). Release generates nothing.
- pending[i] set on press event i; cleared when source i is acknowledged. Set and clear in the same cycle: pending stays 1 (new press not lost).
- Press while already pending: no additional state; one pending bit per source.
- FSM:
  - IDLE: if pending != 0, cause <= lowest-index pending bit, go ASSERT.
  - ASSERT: int_out=1, cause held. On ack: clear pending[cause], cause <= 0, int_out <= 0, load holdoff counter, go HOLDOFF.
  - HOLDOFF: count HOLDOFF_CYCLES cycles, then IDLE. ack ignored.
- ack in IDLE or HOLDOFF is ignored and logged by nothing.
- servo_en: cleared on any press event; set by servo_en_set only if FSM=IDLE and pending=0 and no press event that cycle; otherwise servo_en_set is ignored (clear wins).
- Priority fixed: lower index wins; a source re-pressed during servicing of another is served next in index order, no starvation guarantee beyond that.

## Timing
- Without DEBOUNCE_EN: first edge N sampling sw[i]=0 -> pending[i]=1 after edge N+2; int_out=1 after edge N+3 (if IDLE).
- With DEBOUNCE_EN: add DEBOUNCE_CYCLES cycles between synchroniser output and press event.
- Pulses shorter than 2 clocks may be missed (no guarantee); with DEBOUNCE_EN, any glitch shorter than DEBOUNCE_CYCLES is filtered.
- ack sampled at edge M -> int_out=0, cause=0, pending bit clear after edge M; next int_out rise no earlier than edge M+HOLDOFF_CYCLES+2.
- servo_en changes one cycle after the qualifying press event or servo_en_set.
- reset_n low mid-operation: all outputs to reset values immediately (asynchronous), pending events discarded.

## Configuration
- SERVO_INT_DEBOUNCE_EN defined: per-source debounce counter after the synchroniser; debounced state changes only after DEBOUNCE_CYCLES consecutive equal samples differing from the current state; counter resets on any mismatch.
- Undefined: no counter, synchroniser output feeds edge detection directly; DEBOUNCE_CYCLES unused.

## Structure
- Package servo_int_pkg: FSM state enum (IDLE, ASSERT, HOLDOFF), counter width helper constant, default parameter values.
- One sub-module: sw_debounce (synchroniser + optional debounce + press-edge detect for one source), instantiated NUM_SRC times.
- Priority select, pending register, FSM, servo_en logic in the top.

## Test plan
- Reset then sw=2'b10 held (no debounce) -> pending=01 after 3 edges, int_out=1, cause=01, servo_en=0; ack pulse -> int_out=0, pending=00.
- sw0 and sw1 pressed same cycle -> cause=01 first; after ack and HOLDOFF_CYCLES=16, int_out rises with cause=10.
- sw0 re-pressed in the cycle ack clears it -> pending[0] remains 1, second interrupt with cause=01 follows holdoff.
- servo_en_set while pending!=0 -> servo_en stays 0; after all acked and IDLE, servo_en_set -> servo_en=1; next press -> 0.
- With SERVO_INT_DEBOUNCE_EN, DEBOUNCE_CYCLES=8: 5-cycle low glitch -> no pending; 8+ cycle press -> exactly one event.
- reset_n asserted while int_out=1 -> int_out, cause, pending, servo_en all 0 without a clock edge.

Source files
------------

// File: rtl/servo_int_ctrl_pkg.sv
// servo_int_pkg: shared FSM states, default parameters and counter width helper.
package servo_int_pkg;
  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;
  localparam int DEF_NUM_SRC = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 1000;
  localparam int DEF_HOLDOFF_CYCLES = 16;
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction
endpackage

// File: rtl/servo_int_ctrl_if.sv
// servo_int_ctrl_if: CPU-facing interrupt and servo-enable signals.
interface servo_int_ctrl_if #(parameter int NUM_SRC = 2);
  logic ack;
  logic servo_en_set;
  logic int_out;
  logic [NUM_SRC-1:0] cause;
  logic [NUM_SRC-1:0] pending;
  logic servo_en;
  modport master (output ack, servo_en_set, input int_out, cause, pending, servo_en);
  modport slave (input ack, servo_en_set, output int_out, cause, pending, servo_en);
endinterface

// File: rtl/servo_int_ctrl_sw_debounce.sv
// sw_debounce: synchronise one active-low switch, optionally debounce, flag presses.
// SERVO_INT_DEBOUNCE_EN enables the stable-level filter and its DEBOUNCE_CYCLES parameter.
module sw_debounce
  import servo_int_pkg::*;
`ifdef SERVO_INT_DEBOUNCE_EN
  #(parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES)
`endif
  (
  input  logic clock,
  input  logic reset_n,
  input  logic sw_n,
  output logic press
);
  logic [1:0] sync;
  logic level, prev;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) sync <= '0;
    else sync <= {sync[0], ~sw_n};
`ifdef SERVO_INT_DEBOUNCE_EN
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  logic [CW-1:0] cnt;
  // level follows the synchroniser only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      level <= 1'b0;
    end else if (sync[1] == level) cnt <= '0;
    else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt <= '0;
      level <= sync[1];
    end else cnt <= cnt + 1'b1;
`else
  assign level = sync[1];
`endif
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) prev <= 1'b0;
    else prev <= level;
  assign press = level & ~prev;
endmodule

// File: rtl/servo_int_ctrl.sv
// servo_int_ctrl: latch switch presses, present them one at a time as an acked interrupt, own servo enable.
// SERVO_INT_DEBOUNCE_EN adds per-source debounce and the DEBOUNCE_CYCLES parameter.
module servo_int_ctrl
  import servo_int_pkg::*;
  #(
  parameter int NUM_SRC = DEF_NUM_SRC,
`ifdef SERVO_INT_DEBOUNCE_EN
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`endif
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic clock,
  input  logic reset_n,
  input  logic [NUM_SRC-1:0] sw,
  servo_int_ctrl_if.slave bus
);
  localparam int HW = cnt_width(HOLDOFF_CYCLES);
  state_t state, state_n;
  logic [NUM_SRC-1:0] press, pending, cause, clr, lowest;
  logic [HW-1:0] hcnt;
  logic servo_en;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    sw_debounce
`ifdef SERVO_INT_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_sw (.clock(clock), .reset_n(reset_n), .sw_n(sw[i]), .press(press[i]));
  end
  assign lowest = pending & (~pending + NUM_SRC'(1));
  always_comb begin
    state_n = state == IDLE ? (|pending ? ASSERT : IDLE) :
              state == ASSERT ? (bus.ack ? HOLDOFF : ASSERT) :
              (hcnt == '0 ? IDLE : HOLDOFF);
    clr = (state == ASSERT && bus.ack) ? cause : '0;
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  // a press landing in the same cycle as its clear must survive
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pending <= '0;
      cause <= '0;
      hcnt <= '0;
      servo_en <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | press;
      cause <= state_n == ASSERT ? (state == IDLE ? lowest : cause) : '0;
      hcnt <= state_n == HOLDOFF ? (state == ASSERT ? HW'(HOLDOFF_CYCLES) : hcnt - 1'b1) : '0;
      servo_en <= |press ? 1'b0 :
                  (bus.servo_en_set && state == IDLE && pending == '0) ? 1'b1 : servo_en;
    end
  assign bus.int_out = state == ASSERT;
  assign bus.cause = cause;
  assign bus.pending = pending;
  assign bus.servo_en = servo_en;
endmodule
